// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch-stage bus: instruction-memory request/ack and decode valid/ready
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] nowPC;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] nextPC;

    modport master (
        output imem_req, imem_addr, instruction, nowPC, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, nextPC
    );

    modport slave (
        input  imem_req, imem_addr, instruction, nowPC, instr_valid,
        output imem_ack, imem_rdata, instr_ready, nextPC
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction-fetch stage; ALIGN_CHK_EN enables the misaligned-PC fault state
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ifu_fetch_if.master      bus,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

`ifdef ALIGN_CHK_EN
    typedef enum logic [1:0] {BOOT, REQ, VALID, FAULT} state_t;
`else
    typedef enum logic [1:0] {BOOT, REQ, VALID} state_t;
`endif

    state_t            state, state_d;
    logic              req_d, valid_d, fault_d;
    logic [31:0]       pc_d, instr_d;
    logic [CNT_W-1:0]  retired_d;
    logic              load, consume;

    assign load    = (state == REQ)   && bus.imem_ack;
    assign consume = (state == VALID) && bus.instr_ready;

    // The address comes straight from the held PC; it only matters while imem_req=1.
    assign bus.imem_addr = bus.nowPC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            BOOT:  state_d = REQ;
            REQ:   if (bus.imem_ack) state_d = VALID;
            VALID: begin
                if (bus.instr_ready) begin
`ifdef ALIGN_CHK_EN
                    state_d = (bus.nextPC[1:0] != 2'b00) ? FAULT : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
`ifdef ALIGN_CHK_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        req_d     = (state_d == REQ);
        valid_d   = (state_d == VALID);
        instr_d   = load ? bus.imem_rdata : bus.instruction;
        retired_d = consume ? retired + CNT_W'(1) : retired;
        fault_d   = fault;
        pc_d      = bus.nowPC;
        if (consume) begin
`ifdef ALIGN_CHK_EN
            pc_d    = bus.nextPC;
            fault_d = fault | (bus.nextPC[1:0] != 2'b00);
`else
            pc_d    = bus.nextPC & ~32'h0000_0003;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instruction <= 32'h0000_0000;
            bus.nowPC       <= RESET_PC;
            retired         <= '0;
            fault           <= 1'b0;
        end else begin
            bus.imem_req    <= req_d;
            bus.instr_valid <= valid_d;
            bus.instruction <= instr_d;
            bus.nowPC       <= pc_d;
            retired         <= retired_d;
            fault           <= fault_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] retired;
    logic        fault;
    int          checks = 0;
    int          failures = 0;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .retired (retired),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus.nextPC = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pc", bus.nowPC, 32'h3000);
        chk("rst_retired", retired, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);

        // Streaming: ack and ready held high
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0011;
        bus.nextPC = 32'h3004;
        tick();
        chk("boot_req", {31'b0, bus.imem_req}, 32'h1);
        chk("addr0", bus.imem_addr, 32'h3000);
        tick();
        chk("v0_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("v0_instr", bus.instruction, 32'h0000_0011);
        chk("v0_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("addr1", bus.imem_addr, 32'h3004);
        chk("ret1", retired, 32'd1);
        bus.nextPC = 32'h3008;
        bus.imem_rdata = 32'h0000_0022;
        tick();
        chk("v1_instr", bus.instruction, 32'h0000_0022);
        tick();
        chk("addr2", bus.imem_addr, 32'h3008);
        chk("ret2", retired, 32'd2);
        bus.nextPC = 32'h300C;
        tick();
        tick();
        chk("addr3", bus.imem_addr, 32'h300C);
        chk("ret3", retired, 32'd3);

        // Wait states: ack only in the fourth request cycle
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_req", {31'b0, bus.imem_req}, 32'h1);
            chk("ws_addr", bus.imem_addr, 32'h300C);
            chk("ws_valid", {31'b0, bus.instr_valid}, 32'h0);
        end
        bus.imem_ack = 1'b1;
        tick();
        chk("ws_done_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("ws_done_instr", bus.instruction, 32'h1234_5678);
        chk("ws_done_req", {31'b0, bus.imem_req}, 32'h0);

        // Consumer stall with a stray ack
        bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_instr", bus.instruction, 32'h1234_5678);
            chk("st_pc", bus.nowPC, 32'h300C);
            chk("st_req", {31'b0, bus.imem_req}, 32'h0);
            chk("st_retired", retired, 32'd3);
        end
        bus.imem_ack = 1'b0;

        // Jump redirect then self-loop
        bus.instr_ready = 1'b1;
        bus.nextPC = 32'h0040_0010;
        tick();
        chk("jmp_addr", bus.imem_addr, 32'h0040_0010);
        chk("jmp_ret", retired, 32'd4);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0000_00AA;
        tick();
        chk("self_valid", {31'b0, bus.instr_valid}, 32'h1);
        tick();
        chk("self_addr", bus.imem_addr, 32'h0040_0010);
        chk("self_req", {31'b0, bus.imem_req}, 32'h1);
        chk("self_ret", retired, 32'd5);

        // Reach REQ at 0x3008, then reset asynchronously mid-request
        tick();
        bus.nextPC = 32'h3008;
        tick();
        chk("pre_rst_addr", bus.imem_addr, 32'h3008);
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("arst_pc", bus.nowPC, 32'h3000);
        chk("arst_ret", retired, 32'h0);
        chk("arst_instr", bus.instruction, 32'h0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("boot_ack_req", {31'b0, bus.imem_req}, 32'h1);
        chk("boot_ack_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("boot_ack_instr", bus.instruction, 32'h0);
        chk("post_rst_addr", bus.imem_addr, 32'h3000);
        tick();
        chk("post_rst_instr", bus.instruction, 32'h5555_AAAA);

        // Misaligned next PC
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        bus.nextPC = 32'h3006;
        tick();
        chk("mis_ret", retired, 32'd1);
`ifdef ALIGN_CHK_EN
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_pc", bus.nowPC, 32'h3006);
        chk("mis_req", {31'b0, bus.imem_req}, 32'h0);
        bus.imem_ack = 1'b1;
        tick();
        tick();
        chk("flt_hold_req", {31'b0, bus.imem_req}, 32'h0);
        chk("flt_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("flt_hold_fault", {31'b0, fault}, 32'h1);
`else
        chk("mis_fault", {31'b0, fault}, 32'h0);
        chk("mis_addr", bus.imem_addr, 32'h3004);
        chk("mis_req", {31'b0, bus.imem_req}, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
